// File: rtl/digest_serializer.sv
// Serializes a hash-core digest into BUS_WIDTH words, least-significant word first,
// over a valid/ready handshake. A digest arriving mid-transfer is dropped and flagged.
module digest_serializer #(
    parameter int DIGEST_WIDTH = 88,
    parameter int BUS_WIDTH    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    digest_valid,
    input  logic [DIGEST_WIDTH-1:0] digest,
    output logic [BUS_WIDTH-1:0]    dout,
    output logic                    dout_valid,
    output logic                    dout_last,
    input  logic                    dout_ready,
    output logic                    busy,
    output logic                    overflow,
    output logic [7:0]              digest_count
);

    localparam int NWORDS = (DIGEST_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int EXT_W  = NWORDS * BUS_WIDTH;
    localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
    localparam logic            ONE_WORD = (NWORDS == 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]           r_state;
    logic [EXT_W-1:0]     r_buf;
    logic [IDXW-1:0]      r_idx;
    logic [BUS_WIDTH-1:0] r_dout;
    logic                 r_dout_valid;
    logic                 r_dout_last;
    logic                 r_overflow;
    logic [7:0]           r_count;

    logic [EXT_W-1:0]     w_ext;
    logic [BUS_WIDTH-1:0] w_words [NWORDS];
    logic [IDXW-1:0]      w_next_idx;
    logic                 w_xfer;
    logic                 w_is_last;
    logic                 w_done;
    logic                 w_capture;

    always_comb begin
        w_ext                   = '0;
        w_ext[DIGEST_WIDTH-1:0] = digest;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_words
            assign w_words[gi] = r_buf[gi*BUS_WIDTH +: BUS_WIDTH];
        end
    endgenerate

    // dout_valid is high exactly while in SEND, so it doubles as the state qualifier.
    assign w_xfer     = r_dout_valid & dout_ready;
    assign w_is_last  = (r_idx == LAST_IDX);
    assign w_done     = w_xfer & w_is_last;
    assign w_next_idx = r_idx + 1'b1;
    assign w_capture  = digest_valid & ((r_state == S_IDLE) | w_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_buf        <= '0;
            r_idx        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_overflow   <= 1'b0;
            r_count      <= '0;
        end else begin
            if (w_capture) begin
                r_state      <= S_SEND;
                r_buf        <= w_ext;
                r_idx        <= '0;
                r_dout       <= w_ext[BUS_WIDTH-1:0];
                r_dout_valid <= 1'b1;
                r_dout_last  <= ONE_WORD;
            end else if (w_done) begin
                r_state      <= S_IDLE;
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
                r_dout_last  <= 1'b0;
            end else if (w_xfer) begin
                r_idx        <= w_next_idx;
                r_dout       <= w_words[w_next_idx];
                r_dout_last  <= (w_next_idx == LAST_IDX);
            end

            if (w_done) begin
                r_count <= r_count + 8'd1;
            end

            // A digest can only be taken in SEND on the cycle the last word leaves.
            if (digest_valid && (r_state == S_SEND) && !w_done) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign dout         = r_dout;
    assign dout_valid   = r_dout_valid;
    assign dout_last    = r_dout_last;
    assign busy         = r_state[0];
    assign overflow     = r_overflow;
    assign digest_count = r_count;

endmodule

// File: tb/tb_digest_serializer.sv
// Directed bench for digest_serializer at default parameters (88-bit digest, 64-bit bus).
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_digest_serializer;

    logic        clk;
    logic        reset;
    logic        digest_valid;
    logic [87:0] digest;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        dout_ready;
    logic        busy;
    logic        overflow;
    logic [7:0]  digest_count;

    int checks_cnt;
    int errors_cnt;

    localparam logic [87:0] D_A  = 88'h112233445566778899AABB;
    localparam logic [63:0] A_W0 = 64'h445566778899AABB;
    localparam logic [63:0] A_W1 = 64'h0000000000112233;
    localparam logic [87:0] D_B  = 88'hFEDCBA9876543210CAFE01;

    digest_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .digest_valid (digest_valid),
        .digest       (digest),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_last    (dout_last),
        .dout_ready   (dout_ready),
        .busy         (busy),
        .overflow     (overflow),
        .digest_count (digest_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [63:0] w, input logic last);
        check({tag, ".dout"}, dout, w);
        check({tag, ".valid"}, {63'd0, dout_valid}, 64'd1);
        check({tag, ".last"}, {63'd0, dout_last}, {63'd0, last});
    endtask

    task automatic check_idle(input string tag, input logic [7:0] cnt);
        check({tag, ".dout"}, dout, 64'd0);
        check({tag, ".valid"}, {63'd0, dout_valid}, 64'd0);
        check({tag, ".last"}, {63'd0, dout_last}, 64'd0);
        check({tag, ".busy"}, {63'd0, busy}, 64'd0);
        check({tag, ".count"}, {56'd0, digest_count}, {56'd0, cnt});
    endtask

    initial begin
        checks_cnt   = 0;
        errors_cnt   = 0;
        reset        = 1'b1;
        digest_valid = 1'b0;
        digest       = '0;
        dout_ready   = 1'b0;
        tick();
        tick();
        check_idle("rst", 8'd0);
        check("rst.ovf", {63'd0, overflow}, 64'd0);
        reset = 1'b0;

        // dout_ready with nothing pending changes nothing
        dout_ready = 1'b1;
        tick();
        tick();
        check_idle("idle_ready", 8'd0);

        // Basic two-word transfer with ready held high
        digest = D_A; digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        check_word("basic.w0", A_W0, 1'b0);
        check("basic.busy", {63'd0, busy}, 64'd1);
        tick();
        check_word("basic.w1", A_W1, 1'b1);
        tick();
        check_idle("basic.end", 8'd1);

        // Backpressure: word 0 must hold while ready is low
        dout_ready = 1'b0;
        digest = D_A; digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_word($sformatf("hold%0d", i), A_W0, 1'b0);
            tick();
        end
        dout_ready = 1'b1;
        tick();
        check_word("hold.w1", A_W1, 1'b1);
        tick();
        check_idle("hold.end", 8'd2);

        // Overflow: second pulse while the first is still pending is dropped
        dout_ready = 1'b0;
        digest = D_A; digest_valid = 1'b1;
        tick();
        digest = D_B;
        tick();
        digest_valid = 1'b0;
        check("ovf.flag", {63'd0, overflow}, 64'd1);
        check_word("ovf.w0", A_W0, 1'b0);
        dout_ready = 1'b1;
        tick();
        check_word("ovf.w1", A_W1, 1'b1);
        tick();
        check_idle("ovf.end", 8'd3);
        check("ovf.sticky", {63'd0, overflow}, 64'd1);

        // Reset while word 0 is pending clears everything immediately
        dout_ready = 1'b0;
        digest = D_B; digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        check_word("prerst.w0", 64'h9876543210CAFE01, 1'b0);
        reset = 1'b1;
        #1;
        check_idle("async_rst", 8'd0);
        check("async_rst.ovf", {63'd0, overflow}, 64'd0);
        #2;
        reset = 1'b0;
        tick();
        check_idle("post_rst", 8'd0);
        dout_ready = 1'b1;
        digest = D_B; digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        check_word("post_rst.w0", 64'h9876543210CAFE01, 1'b0);
        tick();
        check_word("post_rst.w1", 64'h0000000000FEDCBA, 1'b1);

        // New digest on the last-word transfer cycle is accepted without overflow
        tick();
        check_idle("chain.idle", 8'd1);
        digest = D_A; digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        check_word("chain.a0", A_W0, 1'b0);
        tick();
        check_word("chain.a1", A_W1, 1'b1);
        digest = 88'h1; digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        check_word("chain.b0", 64'h1, 1'b0);
        check("chain.ovf", {63'd0, overflow}, 64'd0);
        check("chain.cnt_mid", {56'd0, digest_count}, 64'd2);
        tick();
        check_word("chain.b1", 64'h0, 1'b1);
        tick();
        check_idle("chain.end", 8'd3);

        // 256 back-to-back digests wrap the counter
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            digest = 88'(i) | (88'hA5 << 64); digest_valid = 1'b1;
            tick();
            digest_valid = 1'b0;
            if (i % 32 == 0) begin
                check($sformatf("b2b%0d.w0", i), dout, 64'(i));
            end
            tick();
            if (i == 127) begin
                check("b2b.cnt127", {56'd0, digest_count}, 64'd127);
            end
        end
        check_word("b2b.last_w1", 64'hA5, 1'b1);
        tick();
        check_idle("b2b.end", 8'd0);
        check("b2b.ovf", {63'd0, overflow}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/digest_serializer.md
DIGEST_SERIALIZER -- requirements
Module: digest_serializer

Interface
REQ-001 Parameter DIGEST_WIDTH, default 88, SHALL set the hash core digest width in bits (1..512).
REQ-002 Parameter BUS_WIDTH, default 64, SHALL set the output word width in bits.
REQ-003 Derived constant NWORDS SHALL equal ceil(DIGEST_WIDTH/BUS_WIDTH); default 2.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 digest_valid  input  1  SHALL be the one-cycle pulse from the hash core marking digest as valid.
REQ-007 digest  input  DIGEST_WIDTH  SHALL be the hash core digest, sampled only when digest_valid=1.
REQ-008 dout  output  BUS_WIDTH  SHALL be the current output word.
REQ-009 dout_valid  output  1  SHALL be high while dout holds a word not yet accepted.
REQ-010 dout_last  output  1  SHALL be high with dout_valid on word NWORDS-1 only.
REQ-011 dout_ready  input  1  SHALL be the downstream accept; a transfer occurs on a cycle with dout_valid=1 and dout_ready=1.
REQ-012 busy  output  1  SHALL be high whenever a captured digest is not fully transferred.
REQ-013 overflow  output  1  SHALL be a sticky flag marking a dropped digest.
REQ-014 digest_count  output  8  SHALL count fully transferred digests.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE and SEND.
REQ-016 In IDLE, digest_valid=1 SHALL capture digest into an internal register, zero-extended on the MSB side to NWORDS*BUS_WIDTH bits, clear the word index, and enter SEND.
REQ-017 Latency: digest_valid at cycle N SHALL give dout_valid=1 with word 0 at cycle N+1.
REQ-018 Word k SHALL be bits [k*BUS_WIDTH +: BUS_WIDTH] of the extended register; least-significant word first.
REQ-019 In SEND, dout_valid SHALL be 1; dout and dout_last SHALL stay stable until transfer.
REQ-020 On transfer of a non-last word, the index SHALL increment and the next word SHALL appear the following cycle with no bubble.
REQ-021 On transfer of the last word, the FSM SHALL return to IDLE and digest_count SHALL increment by 1, wrapping 255->0.
REQ-022 digest_valid in SEND, except on the last-word transfer cycle, SHALL be dropped and SHALL set overflow; the in-flight digest SHALL be unaffected.
REQ-023 digest_valid on the last-word transfer cycle SHALL be accepted: capture, index=0, stay in SEND; overflow unchanged; digest_count still increments.
REQ-024 dout_ready without dout_valid SHALL have no effect.
REQ-025 busy SHALL equal (state==SEND).
REQ-026 In IDLE, dout SHALL be all zeros and dout_last 0.
REQ-027 All outputs SHALL be driven from registers; no combinational path from dout_ready or digest_valid to any output.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, dout=0, dout_valid=0, dout_last=0, busy=0, overflow=0, digest_count=0, index=0, capture register=0.
REQ-029 Reset mid-SEND SHALL abort the digest with no further words output.
REQ-030 The first capture SHALL be possible on the first rising edge after reset deasserts.
REQ-031 overflow SHALL be cleared only by reset.

Verification
REQ-032 Default params, dout_ready=1, digest=88'h112233445566778899AABB pulsed at N -> N+1: dout=64'h445566778899AABB, last=0; N+2: dout=64'h0000000000112233, last=1; N+3: dout_valid=0, digest_count=1.
REQ-033 Same digest, dout_ready=0 for 5 cycles then 1 -> word 0 held stable for 5 cycles, then both words on consecutive cycles.
REQ-034 Second digest_valid one cycle after the first, dout_ready=0 -> overflow=1 from next cycle; the first digest is output intact; digest_count=1.
REQ-035 digest_valid on the last-word transfer cycle with digest=88'h1 -> next cycle: dout=64'h1, dout_valid=1, last=0; overflow=0; digest_count=2 after completion.
REQ-036 reset asserted while word 0 is pending -> all outputs zero at once; a new digest after release serializes normally.
REQ-037 256 back-to-back digests with dout_ready=1 -> digest_count wraps to 0; overflow stays 0.
